// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM state encoding and the buffered request record.
package apb_pkg;

  // Request fields are sized for the widest supported bus; narrower instances zero-extend.
  localparam int unsigned APB_ADDR_MAX = 64;
  localparam int unsigned APB_DATA_MAX = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic [APB_ADDR_MAX-1:0] addr;
    logic                    write;
    logic [APB_DATA_MAX-1:0] wdata;
  } apb_req_t;

endpackage

// File: rtl/apb_if.sv
// APB bus bundle; apb_m is the requester side, apb_s the completer side.
interface apb_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport apb_m (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport apb_s (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_req_fifo.sv
// Two-entry request FIFO; a push and a pop may land in the same cycle.
module apb_req_fifo
  import apb_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     push_i,
  input  apb_req_t data_i,
  input  logic     pop_i,
  output apb_req_t head_o,
  output logic     full_o,
  output logic     empty_o
);

  apb_req_t   mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       push_en;
  logic       pop_en;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= !wr_ptr_q;
      end
      if (pop_en) begin
        rd_ptr_q <= !rd_ptr_q;
      end
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/apb_requester.sv
// APB master that turns a valid/ready request stream into APB transfers with a
// single-entry response register and an optional PREADY timeout.
//   state     | meaning
//   ST_IDLE   | no transfer; start one when a request is queued and the response slot is free
//   ST_SETUP  | PSEL=1, PENABLE=0 for one cycle
//   ST_ACCESS | PSEL=1, PENABLE=1 until PREADY or timeout
module apb_requester
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              HCLK,
  input  logic              n_RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  apb_if.apb_m              apb
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CNT_W-1:0] TO_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  apb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  apb_req_t push_req;
  apb_req_t head_req;
  logic     fifo_full;
  logic     fifo_empty;
  logic     fifo_pop;
  logic     rsp_free;
  logic     timeout_hit;
  logic     unused_head_hi;

  assign push_req = '{addr:  APB_ADDR_MAX'(req_addr),
                      write: req_write,
                      wdata: APB_DATA_MAX'(req_wdata)};
  // Bits above the configured bus widths are always zero.
  assign unused_head_hi = ^(head_req.addr >> ADDR_W) ^ ^(head_req.wdata >> DATA_W);

  apb_req_fifo u_fifo (
    .clk_i   (HCLK),
    .rst_ni  (n_RST),
    .push_i  (req_valid),
    .data_i  (push_req),
    .pop_i   (fifo_pop),
    .head_o  (head_req),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign req_ready   = !fifo_full;
  assign rsp_free    = !rsp_valid_q || rsp_ready;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q && !rsp_ready;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    fifo_pop      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && rsp_free) begin
          state_d  = ST_SETUP;
          cnt_d    = '0;
          paddr_d  = head_req.addr[ADDR_W-1:0];
          pwrite_d = head_req.write;
          pwdata_d = head_req.wdata[DATA_W-1:0];
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        // A PREADY arriving on the limit cycle still completes normally.
        if (apb.PREADY) begin
          state_d       = ST_IDLE;
          fifo_pop      = 1'b1;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : apb.PRDATA;
          rsp_err_d     = apb.PSLVERR;
          rsp_timeout_d = 1'b0;
        end else if (timeout_hit) begin
          state_d       = ST_IDLE;
          fifo_pop      = 1'b1;
          cnt_d         = cnt_q + CNT_W'(1);
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!n_RST) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign apb.PSEL     = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign apb.PENABLE  = (state_q == ST_ACCESS);
  assign apb.PADDR    = paddr_q;
  assign apb.PWRITE   = pwrite_q;
  assign apb.PWDATA   = pwdata_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_timeout  = rsp_timeout_q;

endmodule

// File: tb/tb_apb_requester.sv
// Bench for apb_requester: directed scenarios plus randomized single transfers
// checked against a transaction-level model of latency and response contents.
module tb_apb_requester;

  localparam int TO = 4;
  localparam logic [31:0] RD_KEY = 32'hA5A5_0000;

  logic        HCLK = 1'b0;
  logic        n_RST = 1'b0;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  int          n_pass = 0;
  int          n_chk  = 0;

  always #5 HCLK = ~HCLK;

  apb_if #(.ADDR_W(32), .DATA_W(32)) apb ();

  apb_requester #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .HCLK        (HCLK),
    .n_RST       (n_RST),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_write   (req_write),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .apb         (apb)
  );

  // Expected outcome of one isolated transfer whose completer inserts `waits` low-PREADY cycles.
  function automatic void model(input logic wr, input int waits, input logic [31:0] prd,
                                input logic slv, output logic [31:0] rd, output logic er,
                                output logic to, output int acc, output int trsp);
    if (waits >= TO) begin
      rd = 32'h0; er = 1'b1; to = 1'b1; acc = TO; trsp = 2 + TO;
    end else begin
      rd = wr ? 32'h0 : prd; er = slv; to = 1'b0; acc = waits + 1; trsp = 3 + waits;
    end
  endfunction

  // Issues one request from idle and plays the completer; cycle numbers count negedges after acceptance.
  task automatic run_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                          input int waits, input logic [31:0] prd, input logic slv, input int hold,
                          output int t_psel, output int t_pen, output int acc_len, output int t_rsp,
                          output bit setup_ok, output bit stable_ok, output logic [31:0] rd,
                          output logic er, output logic to, output bit retain_ok);
    int c;
    bit done;
    t_psel = -1; t_pen = -1; acc_len = 0; t_rsp = -1;
    setup_ok = 1'b0; stable_ok = 1'b1; retain_ok = 1'b0;
    rd = 'x; er = 1'bx; to = 1'bx;
    req_addr = addr; req_write = wr; req_wdata = wd; req_valid = 1'b1;
    @(negedge HCLK);
    req_valid = 1'b0;
    c = 0;
    done = 1'b0;
    while (!done && c < 40) begin
      @(negedge HCLK);
      c++;
      apb.PREADY  = 1'b1;
      apb.PRDATA  = $urandom;
      apb.PSLVERR = 1'($urandom_range(0, 1));
      if (apb.PSEL && !apb.PENABLE && t_psel < 0) begin
        t_psel = c;
        setup_ok = (apb.PADDR === addr) && (apb.PWRITE === wr) && (apb.PWDATA === wd);
      end
      if (apb.PSEL && apb.PENABLE) begin
        if (t_pen < 0) t_pen = c;
        acc_len++;
        if (apb.PADDR !== addr || apb.PWRITE !== wr || apb.PWDATA !== wd) stable_ok = 1'b0;
        apb.PREADY  = (acc_len > waits);
        apb.PRDATA  = prd;
        apb.PSLVERR = slv;
      end
      if (rsp_valid === 1'b1 && t_rsp < 0) begin
        t_rsp = c; rd = rsp_rdata; er = rsp_err; to = rsp_timeout;
        retain_ok = !apb.PSEL && (apb.PADDR === addr) && (apb.PWRITE === wr) && (apb.PWDATA === wd);
        for (int h = 0; h < hold; h++) begin
          @(negedge HCLK);
          if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_err !== er || rsp_timeout !== to)
            stable_ok = 1'b0;
        end
        rsp_ready = 1'b1;
        @(negedge HCLK);
        rsp_ready = 1'b0;
        if (rsp_valid !== 1'b0) stable_ok = 1'b0;
        done = 1'b1;
      end
    end
    apb.PREADY = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge HCLK);
    n_chk++;
    if ({apb.PSEL, apb.PENABLE} !== 2'b00)
      $display("FAIL reset_psel: got %b exp 00", {apb.PSEL, apb.PENABLE});
    else n_pass++;
    n_chk++;
    if ({apb.PWRITE, apb.PADDR, apb.PWDATA} !== 65'h0)
      $display("FAIL reset_bus: got %h exp 0", {apb.PWRITE, apb.PADDR, apb.PWDATA});
    else n_pass++;
    n_chk++;
    if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== 35'h0)
      $display("FAIL reset_rsp: got %h exp 0", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata});
    else n_pass++;
    n_RST = 1'b1;
    @(negedge HCLK);
    n_chk++;
    if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b exp 1", req_ready);
    else n_pass++;
  endtask

  task automatic test_write();
    int tp, te, al, tr; bit so, sk, ro; logic [31:0] rd; logic er, to;
    run_xfer(32'h8001_000C, 1'b1, 32'h80, 0, 32'hDEAD_BEEF, 1'b0, 0,
             tp, te, al, tr, so, sk, rd, er, to, ro);
    n_chk++; if (tp !== 1) $display("FAIL write_psel_time: got %0d exp 1", tp); else n_pass++;
    n_chk++; if (te !== 2) $display("FAIL write_penable_time: got %0d exp 2", te); else n_pass++;
    n_chk++; if (so !== 1'b1) $display("FAIL write_setup_payload: got %b exp 1", so); else n_pass++;
    n_chk++; if (tr !== 3) $display("FAIL write_rsp_time: got %0d exp 3", tr); else n_pass++;
    n_chk++; if ({er, rd} !== 33'h0) $display("FAIL write_rsp: got %h exp 0", {er, rd}); else n_pass++;
  endtask

  task automatic test_wait_read();
    int tp, te, al, tr; bit so, sk, ro; logic [31:0] rd; logic er, to;
    run_xfer(32'h8001_0008, 1'b0, 32'h1234_5678, 3, 32'h0000_000A, 1'b0, 2,
             tp, te, al, tr, so, sk, rd, er, to, ro);
    n_chk++; if (al !== 4) $display("FAIL wait_access_len: got %0d exp 4", al); else n_pass++;
    n_chk++; if (sk !== 1'b1) $display("FAIL wait_stable: got %b exp 1", sk); else n_pass++;
    n_chk++; if (rd !== 32'hA) $display("FAIL wait_rdata: got %h exp a", rd); else n_pass++;
    n_chk++; if ({er, to} !== 2'b00) $display("FAIL wait_err: got %b exp 00", {er, to}); else n_pass++;
  endtask

  task automatic test_slverr();
    int tp, te, al, tr; bit so, sk, ro; logic [31:0] rd; logic er, to;
    run_xfer(32'h0000_0040, 1'b0, 32'h0, 0, 32'h5555_AAAA, 1'b1, 0,
             tp, te, al, tr, so, sk, rd, er, to, ro);
    n_chk++; if ({er, to} !== 2'b10) $display("FAIL slverr_flags: got %b exp 10", {er, to}); else n_pass++;
    run_xfer(32'h0000_0044, 1'b1, 32'h77, 0, 32'h0, 1'b0, 0,
             tp, te, al, tr, so, sk, rd, er, to, ro);
    n_chk++; if (tp !== 1) $display("FAIL slverr_next_issue: got %0d exp 1", tp); else n_pass++;
    n_chk++; if (er !== 1'b0) $display("FAIL slverr_next_err: got %b exp 0", er); else n_pass++;
  endtask

  task automatic test_timeout();
    int tp, te, al, tr; bit so, sk, ro; logic [31:0] rd; logic er, to;
    run_xfer(32'h0000_0100, 1'b0, 32'h0, 6, 32'hFFFF_FFFF, 1'b0, 1,
             tp, te, al, tr, so, sk, rd, er, to, ro);
    n_chk++; if (al !== TO) $display("FAIL timeout_access_len: got %0d exp %0d", al, TO); else n_pass++;
    n_chk++; if (tr !== 2 + TO) $display("FAIL timeout_rsp_time: got %0d exp %0d", tr, 2 + TO); else n_pass++;
    n_chk++; if ({er, to, rd} !== {2'b11, 32'h0}) $display("FAIL timeout_rsp: got %h exp %h", {er, to, rd}, {2'b11, 32'h0}); else n_pass++;
    n_chk++; if (ro !== 1'b1) $display("FAIL timeout_psel_drop: got %b exp 1", ro); else n_pass++;
  endtask

  task automatic test_random();
    int tp, te, al, tr, e_al, e_tr, waits, hold; bit so, sk, ro;
    logic [31:0] rd, e_rd, addr, wd, prd; logic er, to, e_er, e_to, wr, slv;
    for (int i = 0; i < 24; i++) begin
      addr = $urandom; wd = $urandom; prd = $urandom;
      wr = 1'($urandom_range(0, 1)); slv = 1'($urandom_range(0, 1));
      waits = $urandom_range(0, 5); hold = $urandom_range(0, 3);
      model(wr, waits, prd, slv, e_rd, e_er, e_to, e_al, e_tr);
      run_xfer(addr, wr, wd, waits, prd, slv, hold, tp, te, al, tr, so, sk, rd, er, to, ro);
      n_chk++; if (tp !== 1 || te !== 2) $display("FAIL rand_phase[%0d]: got %0d/%0d exp 1/2", i, tp, te); else n_pass++;
      n_chk++; if (al !== e_al) $display("FAIL rand_access_len[%0d]: got %0d exp %0d", i, al, e_al); else n_pass++;
      n_chk++; if (tr !== e_tr) $display("FAIL rand_rsp_time[%0d]: got %0d exp %0d", i, tr, e_tr); else n_pass++;
      n_chk++; if (rd !== e_rd) $display("FAIL rand_rdata[%0d]: got %h exp %h", i, rd, e_rd); else n_pass++;
      n_chk++; if ({er, to} !== {e_er, e_to}) $display("FAIL rand_flags[%0d]: got %b exp %b", i, {er, to}, {e_er, e_to}); else n_pass++;
      n_chk++; if ({so, sk, ro} !== 3'b111) $display("FAIL rand_bus[%0d]: got %b exp 111", i, {so, sk, ro}); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];
    int setups = 0;
    bit c_acc = 1'b0;
    rsp_ready = 1'b0;
    apb.PREADY = 1'b1; apb.PSLVERR = 1'b0;
    exp_q = '{32'h100 ^ RD_KEY, 32'h0, 32'h308 ^ RD_KEY};
    req_addr = 32'h100; req_write = 1'b0; req_wdata = 32'h0; req_valid = 1'b1;
    @(negedge HCLK);
    req_addr = 32'h204; req_write = 1'b1; req_wdata = 32'hCAFE;
    @(negedge HCLK);
    if (apb.PSEL && !apb.PENABLE) setups++;
    n_chk++; if (req_ready !== 1'b0) $display("FAIL b2b_full: got %b exp 0", req_ready); else n_pass++;
    req_addr = 32'h308; req_write = 1'b0; req_wdata = 32'h0;
    for (int i = 0; i < 12; i++) begin
      @(negedge HCLK);
      apb.PRDATA = apb.PADDR ^ RD_KEY;
      if (apb.PSEL && !apb.PENABLE) setups++;
      if (c_acc) req_valid = 1'b0;
      else if (req_valid && req_ready) c_acc = 1'b1;
    end
    n_chk++; if (setups !== 1) $display("FAIL b2b_setups_while_blocked: got %0d exp 1", setups); else n_pass++;
    n_chk++; if (c_acc !== 1'b1) $display("FAIL b2b_third_accept: got %b exp 1", c_acc); else n_pass++;
    n_chk++; if ({rsp_valid, rsp_rdata} !== {1'b1, exp_q[0]}) $display("FAIL b2b_first_held: got %h exp %h", {rsp_valid, rsp_rdata}, {1'b1, exp_q[0]}); else n_pass++;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 30 && got_q.size() < 3; i++) begin
      if (rsp_valid === 1'b1) got_q.push_back(rsp_rdata);
      @(negedge HCLK);
      apb.PRDATA = apb.PADDR ^ RD_KEY;
    end
    rsp_ready = 1'b0;
    apb.PREADY = 1'b0;
    n_chk++; if (got_q.size() !== 3) $display("FAIL b2b_rsp_count: got %0d exp 3", got_q.size()); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL b2b_order[%0d]: got %h exp %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int busy = 0;
    int tp, te, al, tr; bit so, sk, ro; logic [31:0] rd; logic er, to;
    apb.PREADY = 1'b0;
    req_addr = 32'h500; req_write = 1'b0; req_wdata = 32'h0; req_valid = 1'b1;
    @(negedge HCLK);
    req_addr = 32'h504;
    @(negedge HCLK);
    req_valid = 1'b0;
    for (int i = 0; i < 10 && apb.PENABLE !== 1'b1; i++) @(negedge HCLK);
    n_chk++; if (apb.PENABLE !== 1'b1) $display("FAIL rstmid_reach_access: got %b exp 1", apb.PENABLE); else n_pass++;
    n_RST = 1'b0;
    @(negedge HCLK);
    n_chk++; if ({apb.PSEL, apb.PENABLE, rsp_valid} !== 3'b000) $display("FAIL rstmid_outputs: got %b exp 000", {apb.PSEL, apb.PENABLE, rsp_valid}); else n_pass++;
    n_RST = 1'b1;
    apb.PREADY = 1'b1;
    @(negedge HCLK);
    n_chk++; if (req_ready !== 1'b1) $display("FAIL rstmid_req_ready: got %b exp 1", req_ready); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      if (apb.PSEL === 1'b1 || rsp_valid === 1'b1) busy++;
      @(negedge HCLK);
    end
    n_chk++; if (busy !== 0) $display("FAIL rstmid_discarded: got %0d busy cycles exp 0", busy); else n_pass++;
    apb.PREADY = 1'b0;
    run_xfer(32'h600, 1'b0, 32'h0, 0, 32'h0BAD_F00D, 1'b0, 0, tp, te, al, tr, so, sk, rd, er, to, ro);
    n_chk++; if ({tr, rd} !== {32'd3, 32'h0BAD_F00D}) $display("FAIL rstmid_recover: got %0d/%h exp 3/0badf00d", tr, rd); else n_pass++;
  endtask

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    apb.PREADY = 1'b0; apb.PRDATA = '0; apb.PSLVERR = 1'b0;
    test_reset();
    test_write();
    test_wait_read();
    test_slverr();
    test_timeout();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/apb_requester.md
APB_REQUESTER -- requirements
Module: apb_requester

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PADDR/req_addr width.
REQ-002 SHALL have parameter DATA_W, default 32, PWDATA/PRDATA/req_wdata/rsp_rdata width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, maximum consecutive PREADY-low ACCESS cycles; 0 disables timeout.
REQ-004 SHALL have port HCLK  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port n_RST  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports req_valid in 1, req_ready out 1  request handshake.
REQ-007 SHALL have ports req_addr in ADDR_W, req_write in 1, req_wdata in DATA_W  request payload, sampled when req_valid && req_ready.
REQ-008 SHALL have ports rsp_valid out 1, rsp_ready in 1  response handshake.
REQ-009 SHALL have ports rsp_rdata out DATA_W, rsp_err out 1, rsp_timeout out 1  response payload.
REQ-010 SHALL have APB master ports PSEL, PENABLE, PWRITE (out 1), PADDR (out ADDR_W), PWDATA (out DATA_W), PRDATA (in DATA_W), PREADY (in 1), PSLVERR (in 1), named to match apb_if.apb_m.

Function
REQ-011 SHALL buffer requests in a 2-entry FIFO; req_ready = !full; push and pop in the same cycle SHALL be allowed.
REQ-012 SHALL implement FSM IDLE, SETUP, ACCESS.
REQ-013 IDLE->SETUP SHALL occur when FIFO non-empty and response slot free (!rsp_valid || rsp_ready this cycle); otherwise remain IDLE.
REQ-014 In SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA from FIFO head; SETUP->ACCESS unconditionally after one cycle.
REQ-015 In ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA SHALL be held unchanged from SETUP.
REQ-016 ACCESS with PREADY=1 SHALL complete: load rsp_rdata=PRDATA for reads and 0 for writes, rsp_err=PSLVERR, rsp_timeout=0; set rsp_valid; pop FIFO; go IDLE.
REQ-017 Latency: request accepted at edge N -> SETUP from edge N+1 -> ACCESS from edge N+2 -> rsp_valid from edge N+3 (zero wait states); minimum 3 cycles per transfer.
REQ-018 Timeout counter SHALL clear on SETUP entry and increment each ACCESS cycle with PREADY=0.
REQ-019 When TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES with PREADY still 0, the transfer SHALL abort: PSEL/PENABLE low next cycle, rsp_err=1, rsp_timeout=1, rsp_rdata=0, FIFO pop, go IDLE.
REQ-020 PREADY=1 in the same cycle the timeout limit is reached SHALL complete normally (REQ-016 wins).
REQ-021 rsp_valid SHALL stay high with stable payload until rsp_ready; it clears on handshake unless a new completion loads the slot in the same cycle.
REQ-022 Outside SETUP/ACCESS, PSEL=PENABLE=0; PADDR/PWRITE/PWDATA SHALL retain last driven values.
REQ-023 PREADY/PSLVERR/PRDATA SHALL be ignored outside ACCESS.
REQ-024 Requests SHALL issue strictly in acceptance order; exactly one response per request.

Reset
REQ-025 On n_RST=0 at a rising edge: state=IDLE, FIFO empty, timeout counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
REQ-026 req_ready SHALL read 1 from the first cycle after reset release.
REQ-027 Reset mid-transfer SHALL abandon the transfer with no response and discard buffered requests.

Structure
REQ-028 Shared package apb_pkg SHALL hold the FSM state enum and the request struct (addr, write, wdata).
REQ-029 The request FIFO SHALL be sub-module apb_req_fifo (depth 2, payload = request struct); FSM, timeout counter and response register stay in apb_requester.

Verification
REQ-030 Write 0x8001000C data 0x80, PREADY=1 -> PSEL at N+1, PENABLE at N+2, PWDATA=0x80, rsp_valid at N+3 with err=0, rdata=0.
REQ-031 Read 0x80010008, PRDATA=0x0000000A, PREADY low 3 ACCESS cycles -> ACCESS lasts 4 cycles, address stable, rsp_rdata=0xA, err=0.
REQ-032 Read with PSLVERR=1, PREADY=1 -> rsp_err=1, rsp_timeout=0, next request still issued.
REQ-033 TIMEOUT_CYCLES=4, PREADY held 0 -> abort after 4 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0, PSEL low next cycle.
REQ-034 Three back-to-back requests, rsp_ready=0 for 10 cycles -> req_ready low after third accept attempt (FIFO full), no second SETUP until first response taken, responses in order.
REQ-035 n_RST low during ACCESS -> PSEL/PENABLE 0 next edge, rsp_valid 0, FIFO empty, req_ready 1 after release.
